// File: rtl/mod12_cnt_sequencer.sv
// ---------------------------------------------------------------------------
// mod12_cnt_sequencer
//
// Purpose:
//   Command-driven controller for a loadable mod-MOD up/down counter. It
//   accepts LOAD / UP / DOWN / SEEK commands over a valid/ready handshake. It
//   drives the counter's mode/load/data_in pins. It keeps a shadow copy of
//   the value the counter should hold.
//
//   Between commands the counter is held by re-loading the shadow value
//   every cycle. SEEK picks the shorter direction around the ring. A tie
//   goes up.
//
// Optional feature:
//   Define MOD12_SEQ_CHECK_EN to compare the counter's data_out against the
//   shadow every cycle. This adds the err_sticky and mism_cnt outputs. When
//   the macro is undefined, cnt_data_out is ignored.
//
// Ports:
//   clk          in   1       single clock, all state on posedge
//   rst          in   1       synchronous reset, active-high
//   cmd_valid    in   1       command present
//   cmd_ready    out  1       command can be accepted (IDLE only)
//   cmd_op       in   2       00 LOAD, 01 UP, 10 DOWN, 11 SEEK
//   cmd_arg      in   CW      LOAD/SEEK target, UP/DOWN step count
//   cnt_mode     out  1       counter mode (1 = up, 0 = down)
//   cnt_load     out  1       counter load
//   cnt_data_in  out  CW      counter load data
//   cnt_data_out in   CW      counter value fed back
//   busy         out  1       command in progress
//   done         out  1       one-cycle pulse after a command completes
//   cmd_err      out  1       one-cycle pulse, illegal LOAD/SEEK target
//   cur_val      out  CW      shadow of the expected counter value
//   err_sticky   out  1       (check build) a mismatch has been seen
//   mism_cnt     out  8       (check build) saturating mismatch count
// ---------------------------------------------------------------------------
module mod12_cnt_sequencer #(
  parameter int MOD    = 12,
  parameter int CW     = 4,
  parameter int STEP_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [CW-1:0] cmd_arg,
  output logic          cnt_mode,
  output logic          cnt_load,
  output logic [CW-1:0] cnt_data_in,
  input  logic [CW-1:0] cnt_data_out,
  output logic          busy,
  output logic          done,
  output logic          cmd_err,
  output logic [CW-1:0] cur_val
`ifdef MOD12_SEQ_CHECK_EN
  ,
  output logic          err_sticky,
  output logic [7:0]    mism_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DOWN,
    S_NOP
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_SEEK = 2'b11;

  // One extra bit so modular arithmetic on CW-bit values cannot overflow.
  localparam logic [CW:0]   MOD_X  = (CW+1)'(MOD);
  localparam logic [CW:0]   HALF_X = (CW+1)'(MOD / 2);
  localparam logic [CW-1:0] MAX_V  = CW'(MOD - 1);

  state_t              state;
  state_t              next_state;
  logic [CW-1:0]       shadow;
  logic [CW-1:0]       arg_q;
  logic [STEP_W-1:0]   steps;
  logic [STEP_W-1:0]   start_steps;
  logic                done_q;
  logic                err_q;
  logic                reject;
  logic                arg_legal;
  logic [CW:0]         diff_raw;
  logic [CW:0]         seek_d;

  // This block holds the state register and the datapath registers.
  // The shadow register moves on the same edge as the counter. It is
  // loaded at the end of the LOAD cycle and stepped on every counting edge.
  // As a result, it always equals the counter value after each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      shadow <= '0;
      arg_q  <= '0;
      steps  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= (state != S_IDLE) && (next_state == S_IDLE);
      err_q  <= reject;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            arg_q <= cmd_arg;
            steps <= start_steps;
          end
        end
        S_LOAD: begin
          shadow <= arg_q;
        end
        S_UP: begin
          shadow <= (shadow == MAX_V) ? '0 : shadow + CW'(1);
          steps  <= steps - STEP_W'(1);
        end
        S_DOWN: begin
          shadow <= (shadow == '0) ? MAX_V : shadow - CW'(1);
          steps  <= steps - STEP_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // This block decodes commands and computes the next state.
  // For SEEK, the signed distance around the ring is folded into a
  // direction and a step count. A distance of exactly half the ring goes up.
  always_comb begin
    next_state  = state;
    reject      = 1'b0;
    start_steps = '0;
    arg_legal   = {1'b0, cmd_arg} < MOD_X;
    diff_raw    = {1'b0, cmd_arg} + MOD_X - {1'b0, shadow};
    seek_d      = (diff_raw >= MOD_X) ? diff_raw - MOD_X : diff_raw;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_LOAD: begin
              if (arg_legal) next_state = S_LOAD;
              else           reject     = 1'b1;
            end
            OP_UP: begin
              start_steps = STEP_W'(cmd_arg);
              next_state  = (cmd_arg == '0) ? S_NOP : S_UP;
            end
            OP_DOWN: begin
              start_steps = STEP_W'(cmd_arg);
              next_state  = (cmd_arg == '0) ? S_NOP : S_DOWN;
            end
            OP_SEEK: begin
              if (!arg_legal) begin
                reject = 1'b1;
              end else if (seek_d == '0) begin
                next_state = S_NOP;
              end else if (seek_d <= HALF_X) begin
                start_steps = STEP_W'(seek_d);
                next_state  = S_UP;
              end else begin
                start_steps = STEP_W'(MOD_X - seek_d);
                next_state  = S_DOWN;
              end
            end
            default: begin
            end
          endcase
        end
      end
      S_LOAD:  next_state = S_IDLE;
      S_NOP:   next_state = S_IDLE;
      S_UP,
      S_DOWN:  if (steps == STEP_W'(1)) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // This block drives all outputs from registers only.
  // Outside counting states the counter is re-loaded so that it holds
  // its value.
  always_comb begin
    cmd_ready   = (state == S_IDLE);
    busy        = (state != S_IDLE);
    done        = done_q;
    cmd_err     = err_q;
    cur_val     = shadow;
    cnt_load    = !((state == S_UP) || (state == S_DOWN));
    cnt_mode    = (state == S_UP);
    cnt_data_in = (state == S_LOAD) ? arg_q : shadow;
  end

`ifdef MOD12_SEQ_CHECK_EN
  logic chk_q;

  // This block compares the counter against the shadow.
  // The counter is driven (loaded or stepped) on every non-reset edge.
  // The comparison therefore starts in the cycle after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q      <= 1'b0;
      err_sticky <= 1'b0;
      mism_cnt   <= '0;
    end else begin
      chk_q <= 1'b1;
      if (chk_q && (cnt_data_out != shadow)) begin
        err_sticky <= 1'b1;
        if (mism_cnt != 8'hFF) mism_cnt <= mism_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_data_out;
  assign unused_data_out = ^cnt_data_out;
`endif

endmodule

// File: tb/tb_mod12_cnt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mod12_cnt_sequencer
//
// Purpose:
//   Scoreboard bench for mod12_cnt_sequencer. A behavioural counter device
//   sits on the cnt_* pins. Every issued command pushes its expected outcome
//   into a queue. That outcome is computed with ring arithmetic. A monitor
//   pops one entry on every done/cmd_err pulse and compares the result.
// ---------------------------------------------------------------------------
module tb_mod12_cnt_sequencer;

  localparam int MOD = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_arg = 4'd0;
  logic       cmd_ready;
  logic       cnt_mode;
  logic       cnt_load;
  logic [3:0] cnt_data_in;
  logic [3:0] cnt_data_out;
  logic       busy;
  logic       done;
  logic       cmd_err;
  logic [3:0] cur_val;
`ifdef MOD12_SEQ_CHECK_EN
  logic       err_sticky;
  logic [7:0] mism_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit is_err;
    int val;
    int lat;
    int steps;
    int dir;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   model_val = 0;

  // This block is the counter device: it loads, or counts up or down mod 12.
  logic [3:0] ctr = 4'd0;
  bit         force_en = 1'b0;
  logic [3:0] force_val = 4'd0;
  assign cnt_data_out = force_en ? force_val : ctr;

  always @(posedge clk) begin
    if (cnt_load)      ctr <= cnt_data_in;
    else if (cnt_mode) ctr <= 4'((int'(ctr) + 1) % MOD);
    else               ctr <= 4'((int'(ctr) + MOD - 1) % MOD);
  end

  always #5 clk = ~clk;

  mod12_cnt_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .cnt_mode     (cnt_mode),
    .cnt_load     (cnt_load),
    .cnt_data_in  (cnt_data_in),
    .cnt_data_out (cnt_data_out),
    .busy         (busy),
    .done         (done),
    .cmd_err      (cmd_err),
    .cur_val      (cur_val)
`ifdef MOD12_SEQ_CHECK_EN
    ,
    .err_sticky   (err_sticky),
    .mism_cnt     (mism_cnt)
`endif
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // The expected outcome is derived from the command rules on the ring 0..11.
  task automatic applyStimulus(input logic [1:0] op, input int arg);
    exp_t e;
    int   n;
    int   d;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      checkOutput("ready_timeout", 0, 1);
      return;
    end
    e.is_err = 1'b0; e.val = model_val; e.lat = 1; e.steps = 0; e.dir = -1;
    case (op)
      2'b00: begin
        if (arg < MOD) begin e.val = arg; model_val = arg; end
        else begin e.is_err = 1'b1; e.lat = 0; end
      end
      2'b01: begin
        e.steps = arg; e.dir = 1;
        e.val = (model_val + arg) % MOD;
        e.lat = (arg == 0) ? 1 : arg;
        model_val = e.val;
      end
      2'b10: begin
        e.steps = arg; e.dir = 0;
        e.val = (model_val + 2 * MOD - arg) % MOD;
        e.lat = (arg == 0) ? 1 : arg;
        model_val = e.val;
      end
      default: begin
        if (arg >= MOD) begin
          e.is_err = 1'b1; e.lat = 0;
        end else begin
          d = (arg - model_val + MOD) % MOD;
          if (d <= MOD / 2) begin e.steps = d; e.dir = 1; end
          else begin e.steps = MOD - d; e.dir = 0; end
          e.lat = (e.steps == 0) ? 1 : e.steps;
          e.val = arg;
          model_val = arg;
        end
      end
    endcase
    exp_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = 4'(arg);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || busy) checkOutput("idle_timeout", 0, 1);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // This monitor counts busy cycles and counting cycles while a command
  // runs. It scores the result on each done or cmd_err pulse.
  int busy_run  = 0;
  int count_run = 0;
  int last_dir  = -1;

  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0; count_run = 0; last_dir = -1;
    end else if (busy) begin
      busy_run++;
      if (!cnt_load) begin
        count_run++;
        last_dir = int'(cnt_mode);
      end
    end else begin
      if (done || cmd_err) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_response", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("resp_err",    int'(cmd_err), int'(mon_e.is_err));
          checkOutput("resp_done",   int'(done),    int'(!mon_e.is_err));
          checkOutput("cur_val",     int'(cur_val), mon_e.val);
          checkOutput("counter_val", int'(ctr),     mon_e.val);
          checkOutput("busy_cycles", busy_run,      mon_e.lat);
          checkOutput("count_steps", count_run,     mon_e.steps);
          if (mon_e.steps > 0) checkOutput("direction", last_dir, mon_e.dir);
        end
      end
      busy_run = 0; count_run = 0; last_dir = -1;
    end
  end

  initial begin
    cycles(3);
    rst = 1'b0;
    checkOutput("rst_busy",    int'(busy), 0);
    checkOutput("rst_ready",   int'(cmd_ready), 1);
    checkOutput("rst_load",    int'(cnt_load), 1);
    checkOutput("rst_data_in", int'(cnt_data_in), 0);
    checkOutput("rst_mode",    int'(cnt_mode), 0);
    checkOutput("rst_cur_val", int'(cur_val), 0);
    checkOutput("rst_done",    int'(done), 0);
    checkOutput("rst_err",     int'(cmd_err), 0);

    // Reset in the middle of an UP aborts it without a done pulse.
    applyStimulus(2'b01, 10);
    cycles(3);
    rst = 1'b1;
    exp_q.delete();
    model_val = 0;
    cycles(2);
    rst = 1'b0;
    checkOutput("abort_busy",    int'(busy), 0);
    checkOutput("abort_load",    int'(cnt_load), 1);
    checkOutput("abort_data_in", int'(cnt_data_in), 0);
    checkOutput("abort_cur_val", int'(cur_val), 0);
    checkOutput("abort_counter", int'(ctr), 0);
    cycles(12);

    // LOAD 7: one load cycle, then the counter holds 7 while idle.
    applyStimulus(2'b00, 7);
    checkOutput("load_pin",     int'(cnt_load), 1);
    checkOutput("load_data_in", int'(cnt_data_in), 7);
    checkOutput("load_busy",    int'(busy), 1);
    waitIdle();
    cycles(3);
    checkOutput("hold_counter", int'(ctr), 7);
    checkOutput("hold_data_in", int'(cnt_data_in), 7);

    // Wrap upward, wrap downward, then a SEEK with a half-ring tie.
    applyStimulus(2'b00, 10);
    applyStimulus(2'b01, 3);
    waitIdle();
    applyStimulus(2'b00, 1);
    applyStimulus(2'b10, 2);
    applyStimulus(2'b11, 5);
    waitIdle();

    // Illegal LOAD target, then a zero-step UP.
    applyStimulus(2'b00, 12);
    applyStimulus(2'b01, 0);
    waitIdle();
    applyStimulus(2'b11, 13);
    applyStimulus(2'b11, int'(cur_val));
    waitIdle();

    for (int i = 0; i < 80; i++) begin
      logic [1:0] op;
      int arg;
      op  = 2'($urandom_range(0, 3));
      arg = (op == 2'b00 || op == 2'b11) ? int'($urandom_range(0, 13))
                                         : int'($urandom_range(0, 15));
      applyStimulus(op, arg);
      if ($urandom_range(0, 3) == 0) cycles(int'($urandom_range(1, 4)));
    end
    waitIdle();

`ifdef MOD12_SEQ_CHECK_EN
    checkOutput("chk_clean_sticky", int'(err_sticky), 0);
    checkOutput("chk_clean_count",  int'(mism_cnt), 0);
    applyStimulus(2'b00, 4);
    waitIdle();
    force_en  = 1'b1;
    force_val = 4'd3;
    cycles(1);
    force_en = 1'b0;
    cycles(2);
    checkOutput("chk_sticky", int'(err_sticky), 1);
    checkOutput("chk_count",  int'(mism_cnt), 1);
    cycles(5);
    checkOutput("chk_sticky_hold", int'(err_sticky), 1);
    checkOutput("chk_count_hold",  int'(mism_cnt), 1);
    rst = 1'b1;
    exp_q.delete();
    model_val = 0;
    cycles(2);
    rst = 1'b0;
    checkOutput("chk_sticky_rst", int'(err_sticky), 0);
    checkOutput("chk_count_rst",  int'(mism_cnt), 0);
`endif

    cycles(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
